// File: rtl/score_display.sv
// Score path ahead of the 8x16 digit glyph ROM.
// Holds a 4-digit BCD running score and a 4-digit BCD high score. It also
// maps the VGA pixel coordinate to a glyph ROM address {digit, row}. The ROM
// row data then becomes a per-pixel score_on, two clock edges after the
// matching (x, y) is presented.
module score_display #(
  parameter logic [9:0] SC_X0 = 10'd560,
  parameter logic [9:0] HI_X0 = 10'd480,
  parameter logic [9:0] Y0    = 10'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        score_tick,
  input  logic        game_run,
  input  logic        game_restart,
  input  logic        game_over,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic        score_on,
  output logic [15:0] score_bcd,
  output logic [15:0] hi_bcd
);

  logic [15:0] score_q, score_d;
  logic [15:0] hi_q, hi_d;
  logic [7:0]  rom_addr_q, rom_addr_d;
  logic [2:0]  col1_q, col1_d;
  logic        v1_q, v1_d;
  logic        score_on_q, score_on_d;

  logic [9:0]  dx_sc, dx_hi, dy;
  logic        in_y, in_sc, in_hi;
  logic [4:0]  dx;
  logic [15:0] src_bcd;
  logic [3:0]  digit;

  // The BCD increment ripples a carry through the digits. It saturates at
  // 9999 instead of wrapping.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (v[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // The next-state score uses the priority order restart, then tick.
  // The high score compares against the score value before this cycle's update.
  always_comb begin
    score_d = score_q;
    if (game_restart) begin
      score_d = 16'h0000;
    end else if (score_tick && game_run) begin
      score_d = bcd_inc(score_q);
    end
    hi_d = hi_q;
    if (game_over && (score_q > hi_q)) begin
      hi_d = score_q;
    end
  end

  // Stage 0: field hit test, digit select and ROM address formation.
  // When both fields hit, the current-score field takes precedence.
  always_comb begin
    dx_sc = x - SC_X0;
    dx_hi = x - HI_X0;
    dy    = y - Y0;
    in_y  = (y >= Y0) && (dy < 10'd16);
    in_sc = video_on && in_y && (x >= SC_X0) && (dx_sc < 10'd32);
    in_hi = video_on && in_y && (x >= HI_X0) && (dx_hi < 10'd32) && !in_sc;
    dx      = in_sc ? dx_sc[4:0] : dx_hi[4:0];
    src_bcd = in_sc ? score_q : hi_q;
    case (dx[4:3])
      2'd0:    digit = src_bcd[15:12];
      2'd1:    digit = src_bcd[11:8];
      2'd2:    digit = src_bcd[7:4];
      default: digit = src_bcd[3:0];
    endcase
    rom_addr_d = (in_sc || in_hi) ? {digit, dy[3:0]} : 8'h00;
    col1_d     = dx[2:0];
    v1_d       = in_sc || in_hi;
  end

  // Stage 2 combinational part: pick the glyph bit. Bit 7 is the leftmost pixel.
  always_comb begin
    score_on_d = v1_q & rom_data[3'd7 - col1_q];
  end

  // Update all registers. Reset clears the counters and both pipeline stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q    <= 16'h0000;
      hi_q       <= 16'h0000;
      rom_addr_q <= 8'h00;
      col1_q     <= 3'd0;
      v1_q       <= 1'b0;
      score_on_q <= 1'b0;
    end else begin
      score_q    <= score_d;
      hi_q       <= hi_d;
      rom_addr_q <= rom_addr_d;
      col1_q     <= col1_d;
      v1_q       <= v1_d;
      score_on_q <= score_on_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign score_on  = score_on_q;
  assign score_bcd = score_q;
  assign hi_bcd    = hi_q;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: a glyph ROM model, an integer score reference model
// and a due-cycle scoreboard.
module tb_score_display;

  localparam int SC_X0 = 560;
  localparam int HI_X0 = 480;
  localparam int Y0    = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        video_on = 1'b0;
  logic        score_tick = 1'b0;
  logic        game_run = 1'b0;
  logic        game_restart = 1'b0;
  logic        game_over = 1'b0;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        score_on;
  logic [15:0] score_bcd;
  logic [15:0] hi_bcd;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Combinational glyph ROM model. "1" is a bar 00011000 on rows 2..13.
  // The other digits use an arbitrary pattern on rows 2..13.
  function automatic logic [7:0] glyph(input logic [7:0] a);
    if (a[3:0] < 4'd2 || a[3:0] > 4'd13) return 8'h00;
    if (a[7:4] == 4'd1) return 8'h18;
    return a ^ 8'hA5;
  endfunction

  assign rom_data = glyph(rom_addr);

  score_display dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
    .score_tick(score_tick), .game_run(game_run),
    .game_restart(game_restart), .game_over(game_over),
    .rom_addr(rom_addr), .rom_data(rom_data), .score_on(score_on),
    .score_bcd(score_bcd), .hi_bcd(hi_bcd)
  );

  // ---------------- reference model ----------------
  int m_score = 0;
  int m_hi    = 0;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic pix_model(input int px, input int py, input bit vo,
                           output logic [7:0] addr, output logic on);
    bit   in_y, in_sc, in_hi;
    int   val, x0, dxi, pw, dig, row;
    logic [7:0] g;
    in_y  = (py >= Y0) && (py < Y0 + 16);
    in_sc = vo && in_y && (px >= SC_X0) && (px < SC_X0 + 32);
    in_hi = vo && in_y && (px >= HI_X0) && (px < HI_X0 + 32) && !in_sc;
    addr  = 8'h00;
    on    = 1'b0;
    if (in_sc || in_hi) begin
      val = in_sc ? m_score : m_hi;
      x0  = in_sc ? SC_X0 : HI_X0;
      dxi = px - x0;
      case (dxi / 8)
        0:       pw = 1000;
        1:       pw = 100;
        2:       pw = 10;
        default: pw = 1;
      endcase
      dig  = (val / pw) % 10;
      row  = py - Y0;
      addr = 8'(dig * 16 + row);
      g    = glyph(addr);
      on   = g[7 - (dxi % 8)];
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [39:0] reg_q[$];
  int          reg_due[$];
  logic [0:0]  pix_q[$];
  int          pix_due[$];
  int checks = 0;
  int errors = 0;

  // The monitor compares each expected value when its due cycle arrives.
  // It samples on the falling edge.
  always @(negedge clk) begin
    logic [39:0] er;
    logic [0:0]  ep;
    if (reg_due.size() > 0 && reg_due[0] == cyc) begin
      er = reg_q.pop_front();
      void'(reg_due.pop_front());
      checks++;
      if ({rom_addr, score_bcd, hi_bcd} !== er) begin
        errors++;
        $display("FAIL regs cyc=%0d got addr=%h score=%h hi=%h want addr=%h score=%h hi=%h",
                 cyc, rom_addr, score_bcd, hi_bcd, er[39:32], er[31:16], er[15:0]);
      end
    end
    if (pix_due.size() > 0 && pix_due[0] == cyc) begin
      ep = pix_q.pop_front();
      void'(pix_due.pop_front());
      checks++;
      if (score_on !== ep[0]) begin
        errors++;
        $display("FAIL score_on cyc=%0d got %b want %b", cyc, score_on, ep[0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input bit tick, input bit run, input bit rest,
                       input bit over, input int px, input int py, input bit vo);
    logic [7:0] addr;
    logic       on;
    int         nxt;
    @(posedge clk);
    #1;
    reset = rst; score_tick = tick; game_run = run; game_restart = rest;
    game_over = over; x = px[9:0]; y = py[9:0]; video_on = vo;
    pix_model(px, py, vo, addr, on);
    if (rst) begin
      m_score = 0;
      m_hi    = 0;
      addr    = 8'h00;
      on      = 1'b0;
      if (pix_due.size() > 0 && pix_due[pix_due.size()-1] == cyc + 1)
        pix_q[pix_q.size()-1] = 1'b0;
    end else begin
      nxt = m_score;
      if (rest) nxt = 0;
      else if (tick && run) nxt = (m_score < 9999) ? m_score + 1 : 9999;
      if (over && m_score > m_hi) m_hi = m_score;
      m_score = nxt;
    end
    reg_q.push_back({addr, to_bcd(m_score), to_bcd(m_hi)});
    reg_due.push_back(cyc + 1);
    pix_q.push_back(on);
    pix_due.push_back(cyc + 2);
  endtask

  task automatic rand_pix(output int px, output int py, output bit vo);
    if ($urandom_range(0, 3) == 0) begin
      px = $urandom_range(0, 799);
      py = $urandom_range(0, 524);
    end else begin
      px = $urandom_range(HI_X0 - 4, SC_X0 + 36);
      py = $urandom_range(Y0 - 2, Y0 + 18);
    end
    vo = ($urandom_range(0, 7) != 0);
  endtask

  task automatic cyc_rand(input bit tick, input bit run, input bit rest, input bit over);
    int px, py;
    bit vo;
    rand_pix(px, py, vo);
    drive(1'b0, tick, run, rest, over, px, py, vo);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) drive(1'b1, 0, 0, 0, 0, 0, 0, 0);
    // The fields stay idle after reset. Pixels are outside the fields or not video.
    for (int i = 0; i < 16; i++)
      drive(1'b0, 0, 0, 0, 0, $urandom_range(0, 470), $urandom_range(40, 500), 1'b1);
    // 1234 ticks are issued. Ticks while game_run is low are ignored.
    for (int i = 0; i < 20; i++) cyc_rand(1, 0, 0, 0);
    for (int i = 0; i < 1234; i++) cyc_rand(1, 1, 0, 0);
    // The high score is committed, then kept across a restart and a lower score.
    cyc_rand(0, 1, 1, 0);
    for (int i = 0; i < 57; i++) cyc_rand(1, 1, 0, 0);
    cyc_rand(0, 1, 0, 1);
    cyc_rand(0, 1, 1, 0);
    for (int i = 0; i < 30; i++) cyc_rand(1, 1, 0, 0);
    cyc_rand(0, 1, 0, 1);
    // A restart and a tick arrive in the same cycle.
    cyc_rand(1, 1, 1, 0);
    // The score reaches 1000. Then the thousands glyph row 2 is shown at columns 0 and 3.
    for (int i = 0; i < 1000; i++) cyc_rand(1, 1, 0, 0);
    drive(1'b0, 0, 1, 0, 0, SC_X0 + 0, Y0 + 2, 1'b1);
    drive(1'b0, 0, 1, 0, 0, SC_X0 + 3, Y0 + 2, 1'b1);
    drive(1'b0, 0, 1, 0, 0, SC_X0 + 4, Y0 + 2, 1'b1);
    // Field boundaries are swept. video_on is low inside a field.
    for (int r = 0; r < 16; r++) begin
      drive(1'b0, 0, 1, 0, 0, SC_X0 - 1,  Y0 + r, 1'b1);
      drive(1'b0, 0, 1, 0, 0, SC_X0 + 32, Y0 + r, 1'b1);
      drive(1'b0, 0, 1, 0, 0, HI_X0 - 1,  Y0 + r, 1'b1);
      drive(1'b0, 0, 1, 0, 0, HI_X0 + 32, Y0 + r, 1'b1);
      drive(1'b0, 0, 1, 0, 0, SC_X0 + 3,  Y0 + r, 1'b0);
      drive(1'b0, 0, 1, 0, 0, SC_X0 + 3,  Y0 - 1, 1'b1);
      drive(1'b0, 0, 1, 0, 0, SC_X0 + 3,  Y0 + 16, 1'b1);
    end
    // game_over and score_tick arrive in the same cycle.
    cyc_rand(1, 1, 0, 1);
    // Reset is asserted mid-line while the pixels are inside the score field.
    for (int i = 0; i < 32; i++) begin
      drive(i == 12, 0, 1, 0, 0, SC_X0 + i, Y0 + 3, 1'b1);
    end
    for (int i = 0; i < 300; i++) cyc_rand(1, 1, 0, 0);
    // Random traffic mixes pulses and pixels.
    for (int i = 0; i < 2000; i++)
      cyc_rand($urandom_range(0, 1), $urandom_range(0, 3) != 0,
               $urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0);
    // The score is taken to saturation and held at 9999.
    cyc_rand(0, 1, 1, 0);
    for (int i = 0; i < 10005; i++) cyc_rand(1, 1, 0, 0);
    cyc_rand(0, 1, 0, 1);
    for (int i = 0; i < 40; i++) cyc_rand(0, 1, 0, 0);
    drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
    // Drain the queues within a bounded number of cycles.
    for (int i = 0; i < 6 && (reg_q.size() + pix_q.size()) > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if ((reg_q.size() + pix_q.size()) > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", reg_q.size() + pix_q.size());
    end
    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Score-path stage that sits directly upstream of the 8x16 digit glyph ROM.
- Keeps a 4-digit BCD running score and a 4-digit BCD high score, and maps the current VGA pixel coordinate to a glyph ROM address (`{digit, row}`).
- Consumes the ROM's 8-bit row data and emits a pipelined per-pixel `score_on` for the pixel mux.
- Glyph ROM is combinational and external to this block.

Parameters:
- `SC_X0`, 10'd560, left x of current-score field (4 digits x 8 px = 32 px wide)
- `HI_X0`, 10'd480, left x of high-score field (32 px wide)
- `Y0`, 10'd16, top y of both fields (16 px tall)

Ports:
- `clk`  in  1  system pixel-domain clock
- `reset`  in  1  synchronous, active-high reset
- `x`  in  10  current pixel x from VGA sync
- `y`  in  10  current pixel y from VGA sync
- `video_on`  in  1  active-video qualifier
- `score_tick`  in  1  one-cycle pulse: add 1 to score
- `game_run`  in  1  high while game is running; score counts only when high
- `game_restart`  in  1  one-cycle pulse: clear current score
- `game_over`  in  1  one-cycle pulse: commit high score
- `rom_addr`  out  8  glyph ROM address `{digit[3:0], row[3:0]}`
- `rom_data`  in  8  glyph ROM row data; bit 7 = leftmost pixel
- `score_on`  out  1  pixel belongs to a lit glyph pixel
- `score_bcd`  out  16  current score, 4 BCD digits, [15:12] = thousands
- `hi_bcd`  out  16  high score, 4 BCD digits

Behaviour:
- Reset (synchronous, `reset`=1 at a clk edge):
  - `score_bcd`=0, `hi_bcd`=0, `rom_addr`=0, `score_on`=0.
  - All pipeline valid/column registers cleared.
  - Reset mid-frame: `score_on` stays 0 for the 2 cycles needed to refill the pipeline.
- Score counter (priority per cycle: reset > `game_restart` > `score_tick`):
  - `game_restart`=1: `score_bcd` <= 0, regardless of `score_tick`.
  - `score_tick`=1 and `game_run`=1: BCD increment with ripple carry. A digit at 9 becomes 0 and carries into the next digit.
  - At 9999 the counter saturates and holds 9999; no wrap.
  - `score_tick` while `game_run`=0 is ignored.
- High score:
  - On `game_over`=1, if `score_bcd` > `hi_bcd` (BCD compare is equal to unsigned compare of the 16-bit vectors), then `hi_bcd` <= `score_bcd`.
  - The comparison uses the pre-update score value of that cycle.
  - `game_restart` never clears `hi_bcd`; only `reset` does.
  - `game_over` and `score_tick` in the same cycle: the compare uses the old score; the increment still applies.
- Pixel path, stage 0 (combinational):
  - `in_sc` = (`x` >= `SC_X0` && `x` < `SC_X0`+32 && `y` >= `Y0` && `y` < `Y0`+16 && `video_on`).
  - `in_hi` = same test with `HI_X0`.
  - `dx` = `x` − field x0 (5 bits); digit index `di` = `dx`[4:3] (0 = thousands, leftmost); `col` = `dx`[2:0]; `row` = (`y`−`Y0`)[3:0].
  - Digit value = selected nibble of `score_bcd` (if `in_sc`) or `hi_bcd` (if `in_hi`).
  - Fields must not overlap; if both are true, `in_sc` wins.
- Pixel path, stage 1 (registered):
  - `rom_addr` <= {digit, `row`}, or 0 when neither region is active.
  - `col1` <= `col`; `v1` <= `in_sc` | `in_hi`.
- Pixel path, stage 2 (registered):
  - `score_on` <= `v1` & `rom_data`[7−`col1`].
- Latency: `score_on` corresponds to the (`x`,`y`) presented 2 clk edges earlier. The downstream pixel mux delays its own coordinates to match.
- Leading zeros are displayed (score 42 shows "0042").
- Digit values sampled in stage 0 use the current register value. A score change mid-line can tear one glyph for one frame; this is accepted.

Test Plan:
- Reset, then hold `reset`=0 with no pulses -> `score_bcd`=16'h0000, `hi_bcd`=16'h0000, `score_on`=0 for all pixels outside fields.
- `game_run`=1, 1234 `score_tick` pulses -> `score_bcd`=16'h1234. Tick from 0x0099 -> 0x0100. Tick from 0x9999 -> holds 0x9999.
- `score_bcd`=0x0057, pulse `game_over` -> `hi_bcd`=0x0057. `game_restart` -> score 0, hi stays 0x0057. Then score 0x0030 plus `game_over` -> hi unchanged.
- `score_bcd`=0x1000, `x`=`SC_X0`+0, `y`=`Y0`+2 -> after 1 clk `rom_addr`=8'h12. With the ROM attached, `score_on`=0 two clks later. Then `x`=`SC_X0`+3 -> `score_on`=1 (glyph "1" row 2 = 00011000).
- Sweep `x`=`SC_X0`−1 and `SC_X0`+32, `y` in field -> `score_on`=0. `video_on`=0 inside field -> `score_on`=0.
- Same cycle: `game_restart` and `score_tick` -> score 0. `reset` asserted mid-line -> `score_on`=0 on the next two edges, then resumes correct output.
